// File: rtl/matmul_transpose_bwd.sv
// Backward matrix-vector stage: grad_in = W^T * grad_out.
// IN_DIM MAC lanes walk the OUT_DIM weight rows, one row per clock.
module matmul_transpose_bwd #(
  parameter int DATA_W  = 32,
  parameter int IN_DIM  = 1,
  parameter int OUT_DIM = 1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [OUT_DIM-1:0][IN_DIM-1:0][DATA_W-1:0]   i_weights,
  input  logic [OUT_DIM-1:0][DATA_W-1:0]               i_grad_out,
  input  logic                                         i_in_valid,
  output logic                                         o_in_ready,
  output logic [IN_DIM-1:0][DATA_W-1:0]                o_grad_in,
  output logic                                         o_out_valid,
  input  logic                                         i_out_ready,
  output logic                                         o_busy
);

  // One spare bit so the row index can step past OUT_DIM-1 without wrapping.
  localparam int IDX_W = $clog2(OUT_DIM) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t                           r_state;
  state_t                           w_next;
  logic [IDX_W-1:0]                 r_idx;
  logic [OUT_DIM-1:0][DATA_W-1:0]   r_g;
  logic [IN_DIM-1:0][DATA_W-1:0]    r_acc;
  logic [IN_DIM-1:0][DATA_W-1:0]    w_row;
  logic [DATA_W-1:0]                w_gsel;
  logic                             w_last;

  // Select the current weight row and its gradient element by comparison,
  // which keeps the wider index from ever addressing past the arrays.
  always_comb begin
    w_row  = '0;
    w_gsel = '0;
    for (int j = 0; j < OUT_DIM; j++) begin
      if (r_idx == IDX_W'(j)) begin
        w_row  = i_weights[j];
        w_gsel = r_g[j];
      end
    end
  end

  assign w_last = (r_idx == IDX_W'(OUT_DIM - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_in_valid) w_next = S_ACCUM;
      S_ACCUM: if (w_last) w_next = S_DONE;
      S_DONE:  if (i_out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_out_valid = (r_state == S_DONE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_grad_in   = r_acc;

  // Products keep only the low DATA_W bits, so all sums wrap modulo 2^DATA_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_g     <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_g   <= i_grad_out;
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        S_ACCUM: begin
          for (int i = 0; i < IN_DIM; i++) begin
            r_acc[i] <= r_acc[i] + DATA_W'($signed(w_row[i]) * $signed(w_gsel));
          end
          r_idx <= r_idx + IDX_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_transpose_bwd.sv
// Bench for matmul_transpose_bwd: a transaction-level model predicts result,
// handshake timing and reset behaviour; one negedge process compares every cycle.
module tb_matmul_transpose_bwd;

  localparam int DW  = 32;
  localparam int IN  = 2;
  localparam int OUT = 3;

  typedef logic [OUT-1:0][IN-1:0][DW-1:0] wmat_t;
  typedef logic [OUT-1:0][DW-1:0]         gvec_t;
  typedef logic [IN-1:0][DW-1:0]          rvec_t;

  logic  clk = 1'b0;
  logic  rst;
  wmat_t weights;
  gvec_t gradOut;
  rvec_t gradIn;
  logic  inValid, inReady, outValid, outReady, busy;

  logic [0:0][0:0][7:0] w8;
  logic [0:0][7:0]      g8;
  logic [0:0][7:0]      gi8;
  logic inValid8, inReady8, outValid8, outReady8, busy8;

  always #5 clk = ~clk;

  matmul_transpose_bwd #(.DATA_W(DW), .IN_DIM(IN), .OUT_DIM(OUT)) dut (
    .clk(clk), .rst(rst), .i_weights(weights), .i_grad_out(gradOut),
    .i_in_valid(inValid), .o_in_ready(inReady), .o_grad_in(gradIn),
    .o_out_valid(outValid), .i_out_ready(outReady), .o_busy(busy)
  );

  matmul_transpose_bwd #(.DATA_W(8), .IN_DIM(1), .OUT_DIM(1)) dut8 (
    .clk(clk), .rst(rst), .i_weights(w8), .i_grad_out(g8),
    .i_in_valid(inValid8), .o_in_ready(inReady8), .o_grad_in(gi8),
    .o_out_valid(outValid8), .i_out_ready(outReady8), .o_busy(busy8)
  );

  int    assertCount = 0;
  int    failCount = 0;
  int    edgeCount = 0;
  int    timeoutCount = 0;
  int    seenTimeouts = 0;
  bit    pending = 0;
  int    acceptEdge = 0;
  rvec_t expResult = '0;
  bit    b2bMode = 0;
  int    lastAccept = -1;
  bit    pinOn = 0;
  rvec_t pinVal = '0;
  bit    pending8 = 0;
  int    accept8Edge = 0;
  logic [7:0] exp8 = '0;
  bit    pin8On = 0;
  logic [7:0] pin8Val = '0;

  always @(posedge clk) edgeCount++;

  // Reference: grad_in[i] = sum_j W[j][i]*g[j], everything modulo 2^DW.
  function automatic rvec_t modelGrad(wmat_t w, gvec_t g);
    rvec_t r;
    logic [DW-1:0] s;
    for (int i = 0; i < IN; i++) begin
      s = '0;
      for (int j = 0; j < OUT; j++) s = s + DW'(w[j][i] * g[j]);
      r[i] = s;
    end
    return r;
  endfunction

  function automatic wmat_t randW();
    wmat_t w;
    for (int j = 0; j < OUT; j++)
      for (int i = 0; i < IN; i++) w[j][i] = $urandom;
    return w;
  endfunction

  function automatic gvec_t randG();
    gvec_t g;
    for (int j = 0; j < OUT; j++) g[j] = $urandom;
    return g;
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] req);
    assertCount++;
    if (act !== req) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Transaction model: an accepted op is outstanding until its output handshake;
  // its result is visible from OUT edges after the accept edge.
  always @(negedge clk) begin : monitor
    int since;
    int since8;
    bit expValid;
    bit expValid8;
    if (timeoutCount != seenTimeouts) begin
      checkOutput("wait_timeout", 64'(timeoutCount), 64'(seenTimeouts));
      seenTimeouts = timeoutCount;
    end
    if (rst) begin
      checkOutput("rst_out_valid", outValid, 1'b0);
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_in_ready", inReady, 1'b1);
      checkOutput("rst_grad_in", gradIn, 64'd0);
      checkOutput("rst_out_valid8", outValid8, 1'b0);
      checkOutput("rst_grad_in8", gi8, 64'd0);
      pending    = 0;
      pending8   = 0;
      lastAccept = -1;
    end else begin
      since    = edgeCount - acceptEdge;
      expValid = pending && (since >= OUT);
      checkOutput("in_ready", inReady, !pending);
      checkOutput("busy", busy, pending);
      checkOutput("out_valid", outValid, expValid);
      if (expValid) begin
        checkOutput("grad_in", gradIn, expResult);
        if (pinOn) checkOutput("grad_in_literal", gradIn, pinVal);
      end
      if (!pending && inValid) begin
        if (b2bMode && lastAccept >= 0)
          checkOutput("b2b_interval", 64'(edgeCount + 1 - lastAccept), 64'(OUT + 2));
        lastAccept = edgeCount + 1;
        acceptEdge = edgeCount + 1;
        pending    = 1;
        expResult  = modelGrad(weights, gradOut);
      end else if (expValid && outReady) begin
        pending = 0;
      end
      if (!b2bMode) lastAccept = -1;

      since8    = edgeCount - accept8Edge;
      expValid8 = pending8 && (since8 >= 1);
      checkOutput("in_ready8", inReady8, !pending8);
      checkOutput("out_valid8", outValid8, expValid8);
      if (expValid8) begin
        checkOutput("grad_in8", gi8, exp8);
        if (pin8On) checkOutput("grad_in8_literal", gi8, pin8Val);
      end
      if (!pending8 && inValid8) begin
        accept8Edge = edgeCount + 1;
        pending8    = 1;
        exp8        = 8'(w8[0][0] * g8[0]);
      end else if (expValid8 && outReady8) begin
        pending8 = 0;
      end
    end
  end

  // Drivers enter and leave at posedge+1 so inputs never move near a sample point.
  task automatic waitAccept();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (inReady) begin
        @(posedge clk); #1;
        return;
      end
    end
    timeoutCount++;
  endtask

  task automatic waitOutValid();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (outValid) return;
    end
    timeoutCount++;
  endtask

  task automatic applyStimulus(wmat_t w, gvec_t g, int hold, bit pin, rvec_t pv);
    weights = w;
    gradOut = g;
    inValid = 1'b1;
    pinOn   = pin;
    pinVal  = pv;
    waitAccept();
    inValid  = 1'b0;
    gradOut  = randG();
    outReady = (hold == 0);
    waitOutValid();
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      outReady = 1'b1;
    end
    @(posedge clk); #1;
    outReady = 1'b0;
    pinOn    = 0;
  endtask

  task automatic run8(logic [7:0] w, logic [7:0] g, logic [7:0] lit);
    w8[0][0] = w;
    g8[0]    = g;
    inValid8 = 1'b1;
    pin8On   = 1;
    pin8Val  = lit;
    @(posedge clk); #1;
    inValid8  = 1'b0;
    outReady8 = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    outReady8 = 1'b0;
    pin8On    = 0;
  endtask

  wmat_t wt;
  gvec_t gA, gB;
  rvec_t pv;

  initial begin
    rst = 1'b1;
    weights = '0; gradOut = '0; inValid = 1'b0; outReady = 1'b0;
    w8 = '0; g8 = '0; inValid8 = 1'b0; outReady8 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    wt[0][0] = 1; wt[0][1] = 2;
    wt[1][0] = 3; wt[1][1] = 4;
    wt[2][0] = 5; wt[2][1] = 6;

    $display("[TB] directed: all-ones gradient");
    gA = '{default: 32'd1};
    pv[0] = 32'd9; pv[1] = 32'd12;
    applyStimulus(wt, gA, 0, 1, pv);

    $display("[TB] directed: signed gradient");
    gA[0] = -32'sd1; gA[1] = 32'd2; gA[2] = 32'd0;
    pv[0] = 32'd5; pv[1] = 32'd6;
    applyStimulus(wt, gA, 0, 1, pv);

    $display("[TB] directed: 8-bit wrap");
    run8(8'd127, 8'd2, 8'hFE);
    run8(8'hFD, 8'd100, 8'hD4);

    $display("[TB] directed: output stall with a waiting source");
    gA = '{default: 32'd1};
    gB[0] = 32'd2; gB[1] = -32'sd1; gB[2] = 32'd1;
    weights = wt; gradOut = gA; inValid = 1'b1;
    pinOn = 1; pinVal[0] = 32'd9; pinVal[1] = 32'd12;
    waitAccept();
    gradOut = gB;
    waitOutValid();
    repeat (5) begin @(posedge clk); #1; end
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    pinVal[0] = 32'd4; pinVal[1] = 32'd6;
    waitAccept();
    inValid = 1'b0;
    waitOutValid();
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    pinOn = 0;

    $display("[TB] directed: reset during accumulation");
    weights = wt; gradOut = randG(); inValid = 1'b1;
    waitAccept();
    inValid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    gA = '{default: 32'd1};
    pv[0] = 32'd9; pv[1] = 32'd12;
    applyStimulus(wt, gA, 1, 1, pv);

    $display("[TB] directed: back-to-back");
    b2bMode = 1;
    weights = wt; outReady = 1'b1; gradOut = randG(); inValid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      waitAccept();
      gradOut = randG();
    end
    inValid = 1'b0;
    repeat (OUT + 3) begin @(posedge clk); #1; end
    outReady = 1'b0;
    b2bMode = 0;

    $display("[TB] random operations");
    for (int n = 0; n < 25; n++) begin
      applyStimulus(randW(), randG(), int'($urandom_range(0, 3)), 0, '0);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    repeat (3) begin @(posedge clk); #1; end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
